// File: rtl/memristor_mult_arbiter.sv
// Round-robin arbiter sharing one memristor 4x4 signed multiplier core among
// NUM_REQ requesters. It sequences the core's start/done protocol with a timeout.
module memristor_mult_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [4*NUM_REQ-1:0]       req_a,
   input  logic [4*NUM_REQ-1:0]       req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [7:0]                 rsp_data,
   output logic                       rsp_err,
   output logic                       mul_start,
   output logic [3:0]                 mul_multiplier,
   output logic [3:0]                 mul_multiplicand,
   input  logic [7:0]                 mul_result,
   input  logic                       mul_done,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   rr_ptr;
   logic [TW-1:0]   timer;
   logic            arb_hit;
   logic [GW-1:0]   arb_idx;
   logic            timeout_hit;

   function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] p, input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      return GW'(s % NUM_REQ);
   endfunction

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [GW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!arb_hit && req_valid[wrap_add(rr_ptr, k)]) begin
            arb_hit = 1'b1;
            arb_idx = wrap_add(rr_ptr, k);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == S_IDLE && arb_hit)
         req_ready[arb_idx] = 1'b1;
   end

   assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (arb_hit)                 state_nx = S_CLEAR;
         S_CLEAR: if (!mul_done)               state_nx = S_RUN;
         S_RUN:   if (mul_done || timeout_hit) state_nx = S_RESP;
         S_RESP:  if (rsp_ready[grant_id])     state_nx = S_IDLE;
         default:                              state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr           <= '0;
         grant_id         <= '0;
         timer            <= '0;
         mul_start        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         rsp_valid        <= '0;
         rsp_data         <= '0;
         rsp_err          <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (arb_hit) begin
                  mul_multiplier   <= req_a[4*arb_idx +: 4];
                  mul_multiplicand <= req_b[4*arb_idx +: 4];
                  grant_id         <= arb_idx;
               end
            end
            S_CLEAR: begin
               // A sticky done from the previous operation must drop before starting.
               if (!mul_done) begin
                  mul_start <= 1'b1;
                  timer     <= '0;
               end
            end
            S_RUN: begin
               timer <= timer + 1'b1;
               if (mul_done) begin
                  rsp_data  <= mul_result;
                  rsp_err   <= 1'b0;
                  mul_start <= 1'b0;
                  rsp_valid <= one_hot(grant_id);
               end else if (timeout_hit) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  mul_start <= 1'b0;
                  rsp_valid <= one_hot(grant_id);
               end
            end
            S_RESP: begin
               if (rsp_ready[grant_id]) begin
                  rsp_valid <= '0;
                  rr_ptr    <= wrap_add(grant_id, 1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memristor_mult_arbiter.sv
// Randomized bench for memristor_mult_arbiter: random requesters, a behavioural
// multiplier core with variable latency and sticky done, and a transaction-level model.
module tb_memristor_mult_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 64;
   localparam int unsigned GW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4*N-1:0]  req_a, req_b;
   logic [7:0]      rsp_data, mul_result;
   logic            rsp_err, mul_start, mul_done, busy;
   logic [3:0]      mul_multiplier, mul_multiplicand;
   logic [GW-1:0]   grant_id;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   memristor_mult_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
      .mul_result(mul_result), .mul_done(mul_done), .busy(busy), .grant_id(grant_id)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] sprod(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[7:0];
   endfunction

   function automatic logic [N-1:0] oh(input int unsigned i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Requester side
   logic [3:0] op_a [N];
   logic [3:0] op_b [N];

   // Transaction-level reference model
   bit          m_busy, m_wait, m_run, m_resp, m_err;
   int unsigned m_rr, m_g, m_cnt;
   logic [3:0]  m_a, m_b;
   logic [7:0]  m_data;
   int          accepted;

   // Behavioural core
   int core_d, core_cnt, core_sticky, force_d;

   function automatic int first_valid();
      for (int unsigned k = 0; k < N; k++)
         if (req_valid[(m_rr + k) % N]) return int'((m_rr + k) % N);
      return -1;
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < N; i++) begin
         req_a[4*i +: 4] = op_a[i];
         req_b[4*i +: 4] = op_b[i];
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_wait = 0; m_run = 0; m_resp = 0; m_err = 0;
      m_rr = 0; m_g = 0; m_cnt = 0; m_data = '0; m_a = '0; m_b = '0;
      core_cnt = 0; core_sticky = 0; mul_done = 1'b0; mul_result = '0;
   endtask

   task automatic check_cycle();
      int g;
      g = first_valid();
      chk("req_ready", req_ready, (!m_busy && g >= 0) ? oh(g) : '0);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_g);
      chk("mul_start", mul_start, m_run);
      if (m_busy) begin
         chk("mul_multiplier", mul_multiplier, m_a);
         chk("mul_multiplicand", mul_multiplicand, m_b);
      end
      chk("rsp_valid", rsp_valid, m_resp ? oh(m_g) : '0);
      if (m_resp) begin
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_err", rsp_err, m_err);
      end
   endtask

   // Applies the effect of one clock edge using the inputs held across it.
   task automatic model_edge();
      int g;
      accepted = -1;
      if (m_resp) begin
         if (rsp_ready[m_g]) begin
            m_resp = 0; m_busy = 0; m_rr = (m_g + 1) % N;
         end
      end else if (m_run) begin
         m_cnt++;
         if (mul_done) begin
            m_run = 0; m_resp = 1; m_err = 0; m_data = sprod(m_a, m_b);
         end else if (m_cnt == TO) begin
            m_run = 0; m_resp = 1; m_err = 1; m_data = '0;
         end
      end else if (m_wait) begin
         if (!mul_done) begin
            m_wait = 0; m_run = 1; m_cnt = 0;
         end
      end else begin
         g = first_valid();
         if (g >= 0) begin
            m_busy = 1; m_wait = 1; m_g = g; m_a = op_a[g]; m_b = op_b[g];
            accepted = g;
            if (force_d > 0) begin
               core_d  = force_d;
               force_d = 0;
            end else begin
               case ($urandom_range(0, 19))
                  0:       core_d = 100000;
                  1:       core_d = TO;
                  2:       core_d = TO + 1;
                  default: core_d = int'($urandom_range(1, 6));
               endcase
            end
         end
      end
   endtask

   task automatic core_update();
      if (mul_start) begin
         core_cnt++;
         if (core_cnt >= core_d) begin
            if (!mul_done) core_sticky = int'($urandom_range(0, 8));
            mul_done   = 1'b1;
            mul_result = sprod(mul_multiplier, mul_multiplicand);
         end else begin
            mul_result = 8'($urandom);
         end
      end else begin
         core_cnt = 0;
         if (mul_done) begin
            if (core_sticky > 0) core_sticky--;
            else begin
               mul_done   = 1'b0;
               mul_result = 8'($urandom);
            end
         end
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (accepted == i) begin
            op_a[i]      = 4'($urandom);
            op_b[i]      = 4'($urandom);
            req_valid[i] = ($urandom_range(0, 3) != 0);
         end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            op_a[i]      = 4'($urandom);
            op_b[i]      = 4'($urandom);
            req_valid[i] = 1'b1;
         end
         rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      pack_ops();
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_edge();
      #1;
      core_update();
      drive_inputs();
   endtask

   initial begin
      int guard;
      rst       = 1'b1;
      force_d   = 3;
      core_d    = 3;
      model_reset();
      for (int i = 0; i < N; i++) begin
         op_a[i] = 4'($urandom);
         op_b[i] = 4'($urandom);
      end
      op_a[0] = 4'h3; op_b[0] = 4'h5;
      op_a[2] = 4'hE; op_b[2] = 4'h3;
      req_valid = 4'b0101;
      rsp_ready = '0;
      pack_ops();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_mul_ops", {mul_multiplier, mul_multiplicand}, 0);
      chk("rst_rsp", {rsp_valid, rsp_data, rsp_err}, 0);
      rst = 1'b0;

      for (int c = 0; c < 4000; c++) step();

      guard = 0;
      while (!m_run && guard < 1000) begin
         step();
         guard++;
      end
      chk("run_reached", mul_start, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_mul_start", mul_start, 0);
      chk("arst_busy", busy, 0);
      chk("arst_grant_id", grant_id, 0);
      chk("arst_req_ready", req_ready, '0);
      chk("arst_mul_ops", {mul_multiplier, mul_multiplicand}, 0);
      chk("arst_rsp", {rsp_valid, rsp_data, rsp_err}, 0);
      model_reset();
      req_valid = '1;
      rst = 1'b0;

      for (int c = 0; c < 500; c++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memristor_mult_arbiter.md
Name: memristor_mult_arbiter

Overview:
- Round-robin scheduler that shares one memristor 4-bit multiplier core among NUM_REQ independent requesters.
- Each requester hands over an operand pair through a valid/ready handshake.
- The block sequences the core's start/done protocol, supervises it with a timeout, and returns the signed 8-bit product, or an error, to the granted requester.
- Sits between the compute clients (AXI front-ends, local sequencers) and the multiplier core, in the multiplier's clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 64, max cycles in RUN waiting for mul_done before error (>=2)

Ports:
clk  in  1  clock (single clock domain)
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  request accepted (one-hot, combinational)
req_a  in  4*NUM_REQ  multiplier operand, requester i at [4i+3:4i]
req_b  in  4*NUM_REQ  multiplicand operand, same packing
rsp_valid  out  NUM_REQ  response valid, one-hot to granted requester
rsp_ready  in  NUM_REQ  response accepted
rsp_data  out  8  signed product (0 on error)
rsp_err  out  1  timeout flag, qualified by rsp_valid
mul_start  out  1  start to multiplier core (level, registered)
mul_multiplier  out  4  operand A to core (registered)
mul_multiplicand  out  4  operand B to core (registered)
mul_result  in  8  signed core product
mul_done  in  1  core done (may be sticky)
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of current or last grant

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, grant_id=0, all registered outputs 0 (mul_start, mul_multiplier, mul_multiplicand, rsp_valid, rsp_data, rsp_err). req_ready is combinational and therefore 0.
- Reset mid-operation aborts silently. No response is issued; operands are discarded.
- Arbitration: in IDLE, grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1 only in IDLE; all other bits 0.
  - Outside IDLE, req_ready=0.
- States:
  - IDLE: when any req_valid is set, the accept takes place on this edge.
    - Latch req_a/req_b of grant into mul_multiplier/mul_multiplicand.
    - grant_id <= grant.
    - Go to CLEAR.
  - CLEAR: wait for mul_done=0, so a sticky done from the previous op is not mistaken.
    - When mul_done=0: mul_start<=1, timer<=0, go to RUN.
    - CLEAR is not timed.
  - RUN: mul_start held 1; timer increments each cycle.
    - If mul_done=1: rsp_data<=mul_result, rsp_err<=0, mul_start<=0, go to RESP.
    - Else if timer==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_err<=1, mul_start<=0, go to RESP.
    - mul_done has priority over timeout in the same cycle.
  - RESP: rsp_valid[grant_id]=1, with rsp_data and rsp_err stable.
    - On rsp_ready[grant_id]=1: rsp_valid<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, go to IDLE.
    - rsp_ready bits of other requesters are ignored.
- Latency: accept edge T; CLEAR at T+1; mul_start high from T+2 (if done already low).
  - Core done seen at cycle T+2+k gives rsp_valid at T+3+k.
  - Minimum request-to-next-accept is 5 cycles.
- No pipelining: one operation in flight at a time.
- Requesters must hold operands until req_ready; operands are captured at accept, so later changes have no effect.
- Operands pass through unmodified; the product is interpreted as signed, with no sign extension or saturation in this block.
- Starvation-free: each valid requester is served within NUM_REQ grants.

Test Plan:
1. Single request, requester 0, a=3, b=5; core model raises done 3 cycles after start -> req_ready[0] pulse; mul_start high 3 cycles; rsp_valid[0]=1 with rsp_data=0x0F, rsp_err=0 at accept+6.
2. Signed: requester 2, a=4'hE (-2), b=4'h3 -> rsp_data=0xFA, rsp_err=0.
3. All four req_valid held high, rsp_ready tied 1 -> grant order 0,1,2,3,0; each response carries its own requester's product; rr_ptr advances after each.
4. Core never raises done, TIMEOUT_CYCLES=64 -> mul_start high exactly 64 cycles, then rsp_err=1, rsp_data=0; a subsequent request completes normally.
5. Sticky done: mul_done held 1 for 5 cycles after accept -> stays in CLEAR, mul_start=0 throughout; start asserts the cycle after done falls.
6. rsp_ready[1] held low 10 cycles in RESP -> rsp_valid[1] and rsp_data stable, req_ready all 0. Separately, assert rst during RUN -> all outputs 0 immediately, busy=0; the next request is granted from requester 0.
